// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that buffers host bytes and launches them one at a time toward the UART transmitter.
// Optional build macro UART_TX_FIFO_LEVEL_EN adds the registered fill-level output port `level`.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    input  logic            tx_done_tick,
    output logic            busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0] level
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t            state_q, state_d;
    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic [DBIT-1:0]   tx_data_q, tx_data_d;
    logic              push, pop;

    // A full FIFO drops the write even when a pop frees a slot on the same edge.
    always_comb begin
        push = wr_en && !full_q;
        pop  = (state_q == IDLE) && !empty_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_data_d = mem[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);
    end

    // tx_start trails the LAUNCH state by one edge so it comes straight from a flop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_q) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (tx_done_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_start_d = (state_q == LAUNCH);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
`ifdef UART_TX_FIFO_LEVEL_EN
    assign level    = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized run against a queue model.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx_start, busy;
    logic [7:0] tx_data;
    logic       tx_done_tick = 1'b0;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [7:0] launches[$];

    uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every launch the transmitter would see.
    always begin
        @(posedge clk);
        #2;
        if (tx_start === 1'b1) begin
            launches.push_back(tx_data);
            $display("[TB] cycle %0d launch byte %02h", cyc, tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic done_tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int cycles);
        cycles = 0;
        while (tx_start !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b0;
        repeat (3) tick();
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", full); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef UART_TX_FIFO_LEVEL_EN
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start !== 1'b0 || empty !== 1'b1) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL reset_idle_hold: got %0d bad cycles want 0", bad); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        int extra = 0;
        launches.delete();
        write_byte(8'hA5);
        tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty: got %b want 0", empty); end
        tick();
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_early_start: got %b want 0", tx_start); end
        tick();
        tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL single_start_latency: got %b want 1", tx_start); end
        tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h want a5", tx_data); end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5) begin
                tests_failed++;
                $display("FAIL single_wait: got start=%b busy=%b data=%h want 0 1 a5", tx_start, busy, tx_data);
            end
        end
        done_tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_clear: got %b want 0", busy); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_start === 1'b1) extra++;
        end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL single_second_pulse: got %0d pulses want 0", extra); end
        tests_run++; if (launches.size() != 1) begin tests_failed++; $display("FAIL single_launch_count: got %0d want 1", launches.size()); end
        $display("[TB] test_single done");
    endtask

    task automatic test_back_to_back();
        int c;
        logic [7:0] exp;
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 8'(i + 1);
            wait_start(40, c);
            tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL b2b_timeout[%0d]: got no start want start", i); end
            tests_run++; if (tx_data !== exp) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", i, tx_data, exp); end
            repeat (19) tick();
            done_tick();
            if (i < 2) begin
                wait_start(40, c);
                tests_run++; if (c != 2) begin tests_failed++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 2", i, c); end
            end
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty: got %b want 1", empty); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got %b want 0", busy); end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_full_drop();
        int c;
        logic [7:0] exp;
        launches.delete();
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_after_17: got %b want 1", full); end
`ifdef UART_TX_FIFO_LEVEL_EN
        tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL full_level: got %0d want 16", level); end
`endif
        write_byte(8'h21);
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_after_drop: got %b want 1", full); end
        tests_run++;
        if (launches.size() != 1 || launches[0] !== 8'h10) begin
            tests_failed++;
            $display("FAIL full_first_launch: got %0d launches want one of 10", launches.size());
        end
        for (int i = 0; i < 16; i++) begin
            exp = 8'(8'h11 + i);
            done_tick();
            wait_start(10, c);
            tests_run++; if (tx_start !== 1'b1 || tx_data !== exp) begin
                tests_failed++; $display("FAIL full_drain[%0d]: got start=%b data=%h want 1 %h", i, tx_start, tx_data, exp);
            end
        end
        done_tick();
        repeat (10) tick();
        tests_run++; if (launches.size() != 17) begin tests_failed++; $display("FAIL full_launch_total: got %0d want 17", launches.size()); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL full_drained_empty: got %b want 1", empty); end
        $display("[TB] test_full_drop done");
    endtask

    task automatic test_push_pop_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] b, exp;
        int c;
        launches.delete();
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            wr_data = b;
            exp_q.push_back(b);
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        exp = exp_q.pop_front();
        tests_run++; if (launches.size() != 1 || launches[0] !== exp) begin
            tests_failed++; $display("FAIL wrap_first: got %0d launches want one of %h", launches.size(), exp);
        end
        for (int r = 0; r < 20; r++) begin
            done_tick();
            b = $urandom;
            write_byte(b);
            exp_q.push_back(b);
            tests_run++; if (full !== 1'b0 || empty !== 1'b0) begin
                tests_failed++; $display("FAIL wrap_flags[%0d]: got full=%b empty=%b want 0 0", r, full, empty);
            end
`ifdef UART_TX_FIFO_LEVEL_EN
            tests_run++; if (level !== 5'd3) begin tests_failed++; $display("FAIL wrap_level[%0d]: got %0d want 3", r, level); end
`endif
            tick();
            exp = exp_q.pop_front();
            tests_run++; if (tx_start !== 1'b1 || tx_data !== exp) begin
                tests_failed++; $display("FAIL wrap_data[%0d]: got start=%b data=%h want 1 %h", r, tx_start, tx_data, exp);
            end
            repeat (3) tick();
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            done_tick();
            wait_start(10, c);
            tests_run++; if (tx_start !== 1'b1 || tx_data !== exp) begin
                tests_failed++; $display("FAIL wrap_drain: got start=%b data=%h want 1 %h", tx_start, tx_data, exp);
            end
        end
        done_tick();
        tests_run++; if (empty !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_end: got empty=%b busy=%b want 1 0", empty, busy);
        end
        $display("[TB] test_push_pop_wrap done");
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b, exp, last;
        int sent = 0, got = 0, cd = -1, n = 0;
        bit in_wait = 0, chk;
        while (got < 40 && n < 4000) begin
            wr_en = 1'b0;
            tx_done_tick = 1'b0;
            if (sent < 40 && (sent - got) < 16 && $urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                wr_en = 1'b1;
                wr_data = b;
                exp_q.push_back(b);
                sent++;
            end
            chk = in_wait;
            if (cd == 0) begin
                tx_done_tick = 1'b1;
                cd = -1;
                in_wait = 0;
            end else if (cd > 0) begin
                cd--;
            end
            tick();
            n++;
            if (tx_start === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                got++;
                tests_run++; if (tx_data !== exp) begin tests_failed++; $display("FAIL rand_data[%0d]: got %h want %h", got, tx_data, exp); end
                last = tx_data;
                in_wait = 1;
                cd = $urandom_range(0, 6);
            end else if (chk) begin
                tests_run++; if (tx_data !== last) begin tests_failed++; $display("FAIL rand_hold: got %h want %h", tx_data, last); end
            end
        end
        wr_en = 1'b0;
        tx_done_tick = 1'b0;
        tests_run++; if (got != 40) begin tests_failed++; $display("FAIL rand_timeout: got %0d launches want 40", got); end
        done_tick();
        repeat (4) tick();
        tests_run++; if (empty !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rand_end: got empty=%b busy=%b want 1 0", empty, busy);
        end
        $display("[TB] test_random done");
    endtask

    task automatic test_reset_mid_frame();
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        reset = 1'b0;
        #1;
        tests_run++; if (full !== 1'b0 || empty !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got full=%b empty=%b start=%b data=%h busy=%b want 0 1 0 00 0",
                     full, empty, tx_start, tx_data, busy);
        end
`ifdef UART_TX_FIFO_LEVEL_EN
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL midrst_level: got %0d want 0", level); end
`endif
        repeat (2) tick();
        reset = 1'b1;
        launches.delete();
        done_tick();
        repeat (10) tick();
        tests_run++; if (launches.size() != 0) begin tests_failed++; $display("FAIL midrst_stray_start: got %0d launches want 0", launches.size()); end
        tests_run++; if (empty !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_idle: got empty=%b busy=%b want 1 0", empty, busy);
        end
        $display("[TB] test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drop();
        test_push_pop_wrap();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
